// File: rtl/jpeg_frame_tracker_pkg.sv
// jpeg_frame_tracker_pkg: shared definitions for the JPEG frame tracker.
//   state_e   - tracker states (marker search through frame done)
//   MRK_*     - JPEG marker bytes used for SOF0 detection
//   IDX_*     - byte positions inside the SOF0 segment payload
package jpeg_frame_tracker_pkg;

  typedef enum logic [2:0] {
    S_SRCH   = 3'd0,
    S_FF     = 3'd1,
    S_SOF    = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  localparam logic [7:0] MRK_FF = 8'hFF;
  localparam logic [7:0] MRK_C0 = 8'hC0;

  // SOF0 payload: Lh Ll P Hh Hl Wh Wl
  localparam logic [2:0] IDX_HH   = 3'd3;
  localparam logic [2:0] IDX_HL   = 3'd4;
  localparam logic [2:0] IDX_WH   = 3'd5;
  localparam logic [2:0] IDX_WL   = 3'd6;
  localparam logic [2:0] IDX_LAST = 3'd6;

endpackage

// File: rtl/jpeg_sof0_parser.sv
// jpeg_sof0_parser: finds the FF C0 marker in the byte stream and captures
// the frame height/width from the SOF0 payload.
//   r_sysclk, r_arst (async, active-high), i_restart (sync clear)
//   i_byte_en/i_byte - JPEG byte stream
//   o_width/o_height - captured dimensions
//   o_hdr_valid      - sticky, nonzero dimensions captured
//   o_err_dim        - sticky, a SOF0 carried a zero dimension
// Once the header is captured the parser parks in S_STREAM and ignores all
// further bytes; S_DONE is tracked by the raster counter in the top level.
module jpeg_sof0_parser
  import jpeg_frame_tracker_pkg::*;
#(
  parameter int DIM_W = 16
) (
  input  logic             r_sysclk,
  input  logic             r_arst,
  input  logic             i_restart,
  input  logic             i_byte_en,
  input  logic [7:0]       i_byte,
  output logic [DIM_W-1:0] o_width,
  output logic [DIM_W-1:0] o_height,
  output logic             o_hdr_valid,
  output logic             o_err_dim
);

  state_e           state_q;
  logic [2:0]       idx_q;
  logic [DIM_W-1:0] width_q, height_q;
  logic             hdr_valid_q, err_dim_q;

  always_ff @(posedge r_sysclk or posedge r_arst) begin
    if (r_arst) begin
      state_q     <= S_SRCH;
      idx_q       <= '0;
      width_q     <= '0;
      height_q    <= '0;
      hdr_valid_q <= 1'b0;
      err_dim_q   <= 1'b0;
    end else if (i_restart) begin
      state_q     <= S_SRCH;
      idx_q       <= '0;
      width_q     <= '0;
      height_q    <= '0;
      hdr_valid_q <= 1'b0;
      err_dim_q   <= 1'b0;
    end else if (i_byte_en) begin
      case (state_q)
        S_SRCH: if (i_byte == MRK_FF) state_q <= S_FF;
        S_FF: begin
          if (i_byte == MRK_C0) begin
            state_q <= S_SOF;
            idx_q   <= '0;
          end else if (i_byte != MRK_FF) begin
            state_q <= S_SRCH;
          end
        end
        S_SOF: begin
          idx_q <= idx_q + 3'd1;
          case (idx_q)
            IDX_HH:  height_q[15:8] <= i_byte;
            IDX_HL:  height_q[7:0]  <= i_byte;
            IDX_WH:  width_q[15:8]  <= i_byte;
            IDX_WL:  width_q[7:0]   <= i_byte;
            default: ;
          endcase
          if (idx_q == IDX_LAST) begin
            // Wl is still on the bus, so check it directly rather than width_q
            if (height_q != '0 && (width_q[15:8] != 8'd0 || i_byte != 8'd0)) begin
              state_q     <= S_STREAM;
              hdr_valid_q <= 1'b1;
            end else begin
              state_q   <= S_SRCH;
              err_dim_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_width     = width_q;
  assign o_height    = height_q;
  assign o_hdr_valid = hdr_valid_q;
  assign o_err_dim   = err_dim_q;

endmodule

// File: rtl/jpeg_frame_tracker.sv
// jpeg_frame_tracker: SOF0 geometry capture plus raster tracking of the
// decoder's RGB pixel stream.
//   r_sysclk, r_arst (async, active-high), i_restart (sync clear, top priority)
//   i_jpg_byte_en/i_jpg_byte      - JPEG byte stream (header search)
//   i_de/i_R/i_G/i_B              - decoded pixel stream
//   o_hdr_valid/o_width/o_height  - captured geometry
//   o_de/o_R/o_G/o_B/o_x/o_y      - registered pixel with raster coordinate
//   o_sol/o_eol/o_eof             - line/frame qualifiers, valid with o_de
//   o_frame_done                  - sticky after the last pixel
//   o_pad_bytes                   - BMP row padding (needs JPEG_FRAME_TRACKER_PAD_EN)
//   o_err_early/o_err_overrun/o_err_dim - stream error flags
// Build option: define JPEG_FRAME_TRACKER_PAD_EN to compute o_pad_bytes,
// otherwise it is tied to 0.
module jpeg_frame_tracker
  import jpeg_frame_tracker_pkg::*;
#(
  parameter int DIM_W           = 16,
  parameter int COLOR_PRECISION = 8
) (
  input  logic                       r_sysclk,
  input  logic                       r_arst,
  input  logic                       i_restart,
  input  logic                       i_jpg_byte_en,
  input  logic [7:0]                 i_jpg_byte,
  input  logic                       i_de,
  input  logic [COLOR_PRECISION-1:0] i_R,
  input  logic [COLOR_PRECISION-1:0] i_G,
  input  logic [COLOR_PRECISION-1:0] i_B,
  output logic                       o_hdr_valid,
  output logic [DIM_W-1:0]           o_width,
  output logic [DIM_W-1:0]           o_height,
  output logic                       o_de,
  output logic [COLOR_PRECISION-1:0] o_R,
  output logic [COLOR_PRECISION-1:0] o_G,
  output logic [COLOR_PRECISION-1:0] o_B,
  output logic [DIM_W-1:0]           o_x,
  output logic [DIM_W-1:0]           o_y,
  output logic                       o_sol,
  output logic                       o_eol,
  output logic                       o_eof,
  output logic                       o_frame_done,
  output logic [1:0]                 o_pad_bytes,
  output logic                       o_err_early,
  output logic                       o_err_overrun,
  output logic                       o_err_dim
);

  logic             hdr_valid;
  logic [DIM_W-1:0] width, height;

  jpeg_sof0_parser #(.DIM_W(DIM_W)) u_parser (
    .r_sysclk    (r_sysclk),
    .r_arst      (r_arst),
    .i_restart   (i_restart),
    .i_byte_en   (i_jpg_byte_en),
    .i_byte      (i_jpg_byte),
    .o_width     (width),
    .o_height    (height),
    .o_hdr_valid (hdr_valid),
    .o_err_dim   (o_err_dim)
  );

  logic [DIM_W-1:0]           x_q, y_q, x_d, y_d, ox_q, oy_q;
  logic [COLOR_PRECISION-1:0] r_q, g_q, b_q;
  logic                       de_q, sol_q, eol_q, eof_q, done_q, early_q, ovr_q;
  logic                       accept, last_x, last_y;

  // hdr_valid && !done_q is S_STREAM; hdr_valid && done_q is S_DONE
  assign accept = i_de & hdr_valid & ~done_q;
  assign last_x = (x_q == width  - DIM_W'(1));
  assign last_y = (y_q == height - DIM_W'(1));
  assign x_d    = last_x ? '0 : x_q + DIM_W'(1);
  assign y_d    = last_x ? y_q + DIM_W'(1) : y_q;

  always_ff @(posedge r_sysclk or posedge r_arst) begin
    if (r_arst) begin
      x_q <= '0; y_q <= '0; ox_q <= '0; oy_q <= '0;
      r_q <= '0; g_q <= '0; b_q <= '0;
      de_q <= 1'b0; sol_q <= 1'b0; eol_q <= 1'b0; eof_q <= 1'b0;
      done_q <= 1'b0; early_q <= 1'b0; ovr_q <= 1'b0;
    end else if (i_restart) begin
      x_q <= '0; y_q <= '0; ox_q <= '0; oy_q <= '0;
      r_q <= '0; g_q <= '0; b_q <= '0;
      de_q <= 1'b0; sol_q <= 1'b0; eol_q <= 1'b0; eof_q <= 1'b0;
      done_q <= 1'b0; early_q <= 1'b0; ovr_q <= 1'b0;
    end else begin
      de_q    <= accept;
      sol_q   <= accept & (x_q == '0);
      eol_q   <= accept & last_x;
      eof_q   <= accept & last_x & last_y;
      early_q <= i_de & ~hdr_valid;
      if (i_de & done_q) ovr_q <= 1'b1;
      if (accept) begin
        r_q  <= i_R;
        g_q  <= i_G;
        b_q  <= i_B;
        ox_q <= x_q;
        oy_q <= y_q;
        x_q  <= x_d;
        y_q  <= y_d;
        if (last_x & last_y) done_q <= 1'b1;
      end
    end
  end

`ifdef JPEG_FRAME_TRACKER_PAD_EN
  // 3*width is DIM_W+2 bits, but only its low 2 bits matter: 3w = w + 2w
  logic [1:0] w3_lo;
  assign w3_lo       = width[1:0] + {width[0], 1'b0};
  assign o_pad_bytes = 2'd0 - w3_lo;  // (4 - n) mod 4
`else
  assign o_pad_bytes = 2'd0;
`endif

  assign o_hdr_valid   = hdr_valid;
  assign o_width       = width;
  assign o_height      = height;
  assign o_de          = de_q;
  assign o_R           = r_q;
  assign o_G           = g_q;
  assign o_B           = b_q;
  assign o_x           = ox_q;
  assign o_y           = oy_q;
  assign o_sol         = sol_q;
  assign o_eol         = eol_q;
  assign o_eof         = eof_q;
  assign o_frame_done  = done_q;
  assign o_err_early   = early_q;
  assign o_err_overrun = ovr_q;

endmodule

// File: doc/jpeg_frame_tracker.md
# jpeg_frame_tracker

Tracks the geometry of the decoded JPEG frame that leaves `jpeg_vievwer`. It extracts the SOF0 height and width from the flash byte stream (`o_jpg_byte_en`/`o_jpg_byte`). It then counts the decoder's RGB pixel stream (`w_de`/`w_R`/`w_G`/`w_B`) into raster coordinates and emits line and frame markers plus BMP row padding. It sits directly downstream of the viewer and feeds any frame sink: display, BMP dump or checksum.

## Interface
- `DIM_W`, 16, width of the dimension and coordinate fields
- `COLOR_PRECISION`, 8, bits per colour channel
- `r_sysclk`  in  1  system clock
- `r_arst`  in  1  reset, asynchronous, active-high
- `i_restart`  in  1  synchronous restart: return to marker search, clear all status
- `i_jpg_byte_en`  in  1  byte strobe from the viewer
- `i_jpg_byte`  in  8  JPEG byte
- `i_de`  in  1  pixel valid
- `i_R`, `i_G`, `i_B`  in  COLOR_PRECISION each  pixel colour
- `o_hdr_valid`  out  1  SOF0 dimensions captured (sticky)
- `o_width`, `o_height`  out  DIM_W  captured frame dimensions
- `o_de`  out  1  registered pixel valid
- `o_R`, `o_G`, `o_B`  out  COLOR_PRECISION  registered colour
- `o_x`, `o_y`  out  DIM_W  coordinate of the pixel on `o_de`
- `o_sol`, `o_eol`, `o_eof`  out  1  start-of-line, end-of-line, last-pixel qualifiers (valid only with `o_de`)
- `o_frame_done`  out  1  sticky after the last pixel
- `o_pad_bytes`  out  2  BMP row padding bytes
- `o_err_early`  out  1  pulse: `i_de` arrived before `o_hdr_valid`
- `o_err_overrun`  out  1  sticky: `i_de` arrived after `o_frame_done`
- `o_err_dim`  out  1  sticky: SOF0 carried a zero width or height

## Operation
- States: S_SRCH, S_FF, S_SOF, S_STREAM, S_DONE. Bytes are consumed only while `i_jpg_byte_en=1`.
- S_SRCH: byte FF goes to S_FF.
- S_FF: C0 goes to S_SOF with the byte index cleared; another FF stays in S_FF; any other byte returns to S_SRCH.
- S_SOF: byte index 0..6 maps to Lh, Ll, P, Hh, Hl, Wh, Wl. Index 3/4 loads `o_height[15:8]/[7:0]`; index 5/6 loads `o_width[15:8]/[7:0]`. After index 6:
  - both dimensions nonzero: go to S_STREAM, `o_hdr_valid=1`.
  - otherwise: set `o_err_dim`, return to S_SRCH.
- From S_STREAM onward, bytes are ignored.
- S_STREAM: each `i_de` produces one `o_de` beat at coordinate (x, y).
  - x increments per beat; at x=width-1, x wraps to 0 and y increments.
  - The beat at x=width-1, y=height-1 asserts `o_eof` and moves to S_DONE, setting `o_frame_done`.
- `i_de` in S_SRCH/S_FF/S_SOF: pixel is dropped (no `o_de`), `o_err_early` pulses for 1 cycle.
- `i_de` in S_DONE: pixel is dropped, `o_err_overrun` set.
- `i_restart`: go to S_SRCH; clear x, y, `o_hdr_valid`, `o_frame_done`, all errors and dimensions. It has priority over a same-cycle byte or pixel.
- `o_pad_bytes = (4 - (3*width mod 4)) mod 4`, computed once from `o_width`. Width 1 gives 1 (3→1), width 5 gives 1 (15→1), width 2 gives 2 (6→2), width 24 gives 0 (72→0).
- Arithmetic: the 3*width product is DIM_W+2 bits wide; only the low 2 bits are needed.

## Timing
- Reset values: all outputs 0, state S_SRCH, x=y=0.
- Pixel path latency is 1 cycle. `o_de`, colour, `o_x`/`o_y`, `o_sol`/`o_eol`/`o_eof` are all registered from the same `i_de` edge.
- `o_hdr_valid` rises the cycle after the Wl byte. A pixel arriving in that same Wl cycle counts as early.
- `o_frame_done` rises with the `o_eof` beat. `o_pad_bytes` is valid from `o_hdr_valid`.
- Back-to-back `i_de` every cycle is supported, with no stall.
- A width-1 frame asserts `o_sol` and `o_eol` on every beat. A 1x1 frame asserts `o_sol`, `o_eol` and `o_eof` together.
- A reset mid-frame drops any in-flight `o_de` immediately (asynchronous).

## Configuration
- `JPEG_FRAME_TRACKER_PAD_EN` defined: `o_pad_bytes` is computed as above.
- `JPEG_FRAME_TRACKER_PAD_EN` undefined: `o_pad_bytes` is tied to 0 and no padding logic is built. All other behaviour is unchanged.

## Structure
- Package `jpeg_frame_tracker_pkg` holds:
  - state encodings
  - marker constants FF and C0
  - SOF byte indices (IDX_HH=3, IDX_HL=4, IDX_WH=5, IDX_WL=6, IDX_LAST=6)
- Sub-module `jpeg_sof0_parser` contains the marker search and dimension capture. It outputs width, height, `hdr_valid` and `err_dim`. The top level holds the raster counter and the pixel register.

## Test plan
- Bytes FF D8 FF C0 00 11 08 00 10 00 18 → `o_height`=16, `o_width`=24, `o_hdr_valid`=1, `o_pad_bytes`=0.
- Same header, then 384 consecutive `i_de` → `o_eol` on x=23 each row; `o_eof` and `o_frame_done` on the beat with x=23, y=15.
- Header width 5, height 2, then 10 beats → `o_pad_bytes`=1; `o_eof` at (4,1); an 11th `i_de` → `o_err_overrun`=1, no `o_de`.
- `i_de` before header, then bytes FF FF C0 … dimensions 1x1 → first pixel dropped with `o_err_early` pulse; after the header, one beat with `o_sol`/`o_eol`/`o_eof`=1.
- SOF0 with height 0 → `o_err_dim`=1, `o_hdr_valid`=0; a following valid SOF0 is still captured.
- `r_arst` asserted after 100 beats of a 24x16 frame → all outputs 0. `i_restart` mid-frame → S_SRCH with status cleared.
